// File: rtl/bp_update_scheduler.sv
// bp_update_scheduler: merges resolved-branch training updates from several
// resolve ports onto the single branch-predictor update port. A mispredict is
// forwarded straight to the output register so BHR repair is never delayed.
// Ordinary training updates go through a circular FIFO that drains one entry
// per cycle whenever no mispredict is using the output.

package bp_update_scheduler_pkg;
  typedef struct packed {
    logic [7:0] idx;   // predictor table index
    logic [7:0] bhr;   // branch history snapshot
    logic [1:0] ctr;   // counter state at prediction time
  } BRANCH_PREDICTOR_PACKET;
endpackage

module bp_update_scheduler
  import bp_update_scheduler_pkg::*;
#(
  parameter int NUM_RES = 2,
  parameter int DEPTH   = 8,
  parameter int CNT_W   = $clog2(DEPTH + 1)
) (
  input  logic                                 clock,
  input  logic                                 reset,
  input  logic [NUM_RES-1:0]                   res_valid,
  input  BRANCH_PREDICTOR_PACKET [NUM_RES-1:0] res_packet,
  input  logic [NUM_RES-1:0]                   res_taken,
  input  logic [NUM_RES-1:0]                   res_mispred,
  output logic                                 resolving_valid_branch,
  output BRANCH_PREDICTOR_PACKET               bs_bp_packet,
  output logic                                 taken,
  output logic                                 mispred,
  output logic [CNT_W-1:0]                     occupancy,
  output logic                                 full,
  output logic [7:0]                           drop_count
);

  // Pointer width: DEPTH is a power of two, so pointer arithmetic wraps for free.
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IDX_W = (NUM_RES > 1) ? $clog2(NUM_RES) : 1;
  // Arithmetic width large enough for occupancy plus a full batch of candidates.
  localparam int AW    = CNT_W + $clog2(NUM_RES + 1);

  // A FIFO entry is the packet plus the resolved direction.
  typedef struct packed {
    BRANCH_PREDICTOR_PACKET pkt;
    logic                   tkn;
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   head_reg;
  logic [PTR_W-1:0]   tail_reg;
  logic [CNT_W-1:0]   occ_reg;

  logic               mp_found;
  logic [IDX_W-1:0]   mp_idx;
  logic [NUM_RES-1:0] cand;
  logic [NUM_RES-1:0] enq_ok;
  logic [AW-1:0]      rank [NUM_RES];
  logic [PTR_W-1:0]   wr_addr [NUM_RES];
  logic [AW-1:0]      cand_cnt;
  logic [AW-1:0]      free_cnt;
  logic [AW-1:0]      enq_cnt;
  logic [AW-1:0]      drop_cnt;
  logic               pop;
  logic [AW-1:0]      occ_next;
  logic [AW+8:0]      drop_sum;
  logic [7:0]         drop_next;

  // Select the oldest (lowest-index) mispredicting port; scanning downward
  // leaves the lowest match as the final assignment.
  always_comb begin
    mp_found = 1'b0;
    mp_idx   = '0;
    for (int i = NUM_RES - 1; i >= 0; i--) begin
      if (res_valid[i] && res_mispred[i]) begin
        mp_found = 1'b1;
        mp_idx   = IDX_W'(i);
      end
    end
  end

  // A port is an enqueue candidate if it is a valid, non-mispredicting branch
  // older than the selected mispredict; younger ports are on the wrong path.
  generate
    for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_cand
      assign cand[gi] = res_valid[gi] && !res_mispred[gi] &&
                        !(mp_found && (IDX_W'(gi) > mp_idx));
    end
  endgenerate

  // Rank each candidate among the candidates below it; this is its slot
  // offset from tail and also its position in the drop ordering.
  always_comb begin
    cand_cnt = '0;
    for (int i = 0; i < NUM_RES; i++) begin
      rank[i]  = cand_cnt;
      cand_cnt = cand_cnt + AW'(cand[i]);
    end
  end

  // Free space is taken from the start-of-cycle occupancy only, so a pop in
  // this same cycle never makes room for an extra candidate.
  assign free_cnt = AW'(DEPTH) - AW'(occ_reg);
  assign enq_cnt  = (cand_cnt < free_cnt) ? cand_cnt : free_cnt;
  assign drop_cnt = cand_cnt - enq_cnt;
  assign pop      = !mp_found && (occ_reg != '0);
  assign occ_next = AW'(occ_reg) + enq_cnt - AW'(pop);

  // Oldest candidates win the free slots; the youngest ones are dropped.
  generate
    for (genvar gi = 0; gi < NUM_RES; gi++) begin : g_wr
      assign enq_ok[gi]  = cand[gi] && (rank[gi] < free_cnt);
      assign wr_addr[gi] = tail_reg + rank[gi][PTR_W-1:0];
    end
  endgenerate

  // Drop counter saturates at 255 rather than wrapping.
  assign drop_sum  = {{AW{1'b0}}, 1'b0, drop_count} + {9'b0, drop_cnt};
  assign drop_next = (drop_sum > (AW+9)'(255)) ? 8'hFF : drop_sum[7:0];

  assign occupancy = occ_reg;
  assign full      = (occ_reg == CNT_W'(DEPTH));

  // FIFO storage: each accepted candidate is written to its own slot past tail.
  always_ff @(posedge clock) begin
    for (int i = 0; i < NUM_RES; i++) begin
      if (enq_ok[i]) begin
        mem[wr_addr[i]] <= '{pkt: res_packet[i], tkn: res_taken[i]};
      end
    end
  end

  // Head/tail pointers and occupancy; reset empties the queue immediately.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      head_reg <= '0;
      tail_reg <= '0;
      occ_reg  <= '0;
    end else begin
      head_reg <= head_reg + PTR_W'(pop);
      tail_reg <= tail_reg + enq_cnt[PTR_W-1:0];
      occ_reg  <= occ_next[CNT_W-1:0];
    end
  end

  // Count training updates lost to a full queue.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_count <= '0;
    end else begin
      drop_count <= drop_next;
    end
  end

  // Update-port register: a mispredict takes priority over the queue head;
  // with nothing to send, packet and direction simply hold.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      resolving_valid_branch <= 1'b0;
      bs_bp_packet           <= '0;
      taken                  <= 1'b0;
      mispred                <= 1'b0;
    end else if (mp_found) begin
      resolving_valid_branch <= 1'b1;
      bs_bp_packet           <= res_packet[mp_idx];
      taken                  <= res_taken[mp_idx];
      mispred                <= 1'b1;
    end else if (pop) begin
      resolving_valid_branch <= 1'b1;
      bs_bp_packet           <= mem[head_reg].pkt;
      taken                  <= mem[head_reg].tkn;
      mispred                <= 1'b0;
    end else begin
      resolving_valid_branch <= 1'b0;
      mispred                <= 1'b0;
    end
  end

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Randomized and directed bench for bp_update_scheduler against a queue-based
// reference model of the scheduling rules.
module tb_bp_update_scheduler;
  import bp_update_scheduler_pkg::*;

  localparam int NUM_RES = 2;
  localparam int DEPTH   = 8;
  localparam int CNT_W   = $clog2(DEPTH + 1);

  logic                                 clock;
  logic                                 reset;
  logic [NUM_RES-1:0]                   res_valid;
  BRANCH_PREDICTOR_PACKET [NUM_RES-1:0] res_packet;
  logic [NUM_RES-1:0]                   res_taken;
  logic [NUM_RES-1:0]                   res_mispred;
  logic                                 resolving_valid_branch;
  BRANCH_PREDICTOR_PACKET               bs_bp_packet;
  logic                                 taken;
  logic                                 mispred;
  logic [CNT_W-1:0]                     occupancy;
  logic                                 full;
  logic [7:0]                           drop_count;

  bp_update_scheduler #(.NUM_RES(NUM_RES), .DEPTH(DEPTH)) dut (
    .clock                  (clock),
    .reset                  (reset),
    .res_valid              (res_valid),
    .res_packet             (res_packet),
    .res_taken              (res_taken),
    .res_mispred            (res_mispred),
    .resolving_valid_branch (resolving_valid_branch),
    .bs_bp_packet           (bs_bp_packet),
    .taken                  (taken),
    .mispred                (mispred),
    .occupancy              (occupancy),
    .full                   (full),
    .drop_count             (drop_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    BRANCH_PREDICTOR_PACKET p;
    logic                   t;
  } ent_t;

  // Reference model state
  ent_t                   q[$];
  logic                   exp_v;
  BRANCH_PREDICTOR_PACKET exp_p;
  logic                   exp_t;
  logic                   exp_m;
  int                     exp_drop;

  int errors;
  int checks;
  int cyc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr_ports();
    res_valid   = '0;
    res_taken   = '0;
    res_mispred = '0;
    res_packet  = '0;
  endtask

  task automatic set_port(input int i, input logic v, input logic t, input logic m,
                          input logic [7:0] idx);
    res_valid[i]   = v;
    res_taken[i]   = t;
    res_mispred[i] = m;
    res_packet[i]  = '{idx: idx, bhr: 8'(i * 17 + idx), ctr: 2'(idx)};
  endtask

  task automatic push2(input logic [7:0] a, input logic [7:0] b);
    clr_ports();
    set_port(0, 1'b1, a[0], 1'b0, a);
    set_port(1, 1'b1, b[0], 1'b0, b);
  endtask

  // One clock: apply the scheduling rules to the current inputs, advance,
  // then compare every observable output with the model.
  task automatic tick();
    int   m;
    int   free;
    ent_t e;
    m    = -1;
    free = DEPTH - q.size();
    for (int i = 0; i < NUM_RES; i++)
      if (m < 0 && res_valid[i] && res_mispred[i]) m = i;
    if (m >= 0) begin
      exp_v = 1'b1; exp_p = res_packet[m]; exp_t = res_taken[m]; exp_m = 1'b1;
    end else if (q.size() > 0) begin
      e = q.pop_front();
      exp_v = 1'b1; exp_p = e.p; exp_t = e.t; exp_m = 1'b0;
    end else begin
      exp_v = 1'b0; exp_m = 1'b0;
    end
    for (int i = 0; i < NUM_RES; i++) begin
      if (res_valid[i] && !res_mispred[i] && (m < 0 || i < m)) begin
        if (free > 0) begin
          e.p = res_packet[i];
          e.t = res_taken[i];
          q.push_back(e);
          free--;
        end else if (exp_drop < 255) begin
          exp_drop++;
        end
      end
    end
    @(posedge clock);
    #1;
    cyc++;
    $display("cyc %0d: in v=%b m=%b -> out v=%b mp=%b idx=%02h t=%b occ=%0d drops=%0d",
             cyc, res_valid, res_mispred, resolving_valid_branch, mispred,
             bs_bp_packet.idx, taken, occupancy, drop_count);
    check("valid", 32'(resolving_valid_branch), 32'(exp_v));
    check("mispred", 32'(mispred), 32'(exp_m));
    if (exp_v) begin
      check("packet", 32'(bs_bp_packet), 32'(exp_p));
      check("taken", 32'(taken), 32'(exp_t));
    end
    check("occupancy", 32'(occupancy), 32'(q.size()));
    check("full", 32'(full), 32'(q.size() == DEPTH));
    check("drop_count", 32'(drop_count), 32'(exp_drop));
  endtask

  task automatic model_reset();
    q.delete();
    exp_v    = 1'b0;
    exp_m    = 1'b0;
    exp_drop = 0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    model_reset();
    reset = 1'b1;
    clr_ports();
    #2;
    check("rst_valid", 32'(resolving_valid_branch), 32'd0);
    check("rst_mispred", 32'(mispred), 32'd0);
    check("rst_occ", 32'(occupancy), 32'd0);
    check("rst_full", 32'(full), 32'd0);
    check("rst_drops", 32'(drop_count), 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;

    // Idle after reset
    for (int i = 0; i < 5; i++) tick();

    // Two training updates in one cycle, drained in order
    clr_ports();
    set_port(0, 1'b1, 1'b1, 1'b0, 8'h12);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h34);
    tick();
    check("tp_occ2", 32'(occupancy), 32'd2);
    clr_ports();
    tick();
    check("tp_idx12", 32'(bs_bp_packet.idx), 32'h12);
    check("tp_tkn12", 32'(taken), 32'd1);
    tick();
    check("tp_idx34", 32'(bs_bp_packet.idx), 32'h34);
    check("tp_occ0", 32'(occupancy), 32'd0);

    // Mispredict bypasses three queued entries and squashes port1
    push2(8'h01, 8'h02); tick();
    push2(8'h03, 8'h04); tick();
    check("mp_occ3_pre", 32'(occupancy), 32'd3);
    clr_ports();
    set_port(0, 1'b1, 1'b1, 1'b1, 8'h55);
    set_port(1, 1'b1, 1'b0, 1'b0, 8'h66);
    tick();
    check("mp_idx55", 32'(bs_bp_packet.idx), 32'h55);
    check("mp_flag", 32'(mispred), 32'd1);
    check("mp_occ3", 32'(occupancy), 32'd3);
    clr_ports();
    for (int i = 0; i < 4; i++) tick();

    // Fill to 7 then overflow by one
    for (int i = 0; i < 6; i++) begin
      push2(8'(8'h20 + 2 * i), 8'(8'h21 + 2 * i));
      tick();
    end
    check("ovf_occ7", 32'(occupancy), 32'd7);
    push2(8'h40, 8'h41);
    tick();
    check("ovf_drop1", 32'(drop_count), 32'd1);
    clr_ports();
    for (int i = 0; i < 9; i++) tick();

    // Both ports mispredict: only the older one is forwarded
    clr_ports();
    set_port(0, 1'b1, 1'b0, 1'b1, 8'hA0);
    set_port(1, 1'b1, 1'b1, 1'b1, 8'hB0);
    tick();
    check("dual_idxA0", 32'(bs_bp_packet.idx), 32'hA0);
    clr_ports();
    tick();
    check("dual_noB0", 32'(resolving_valid_branch), 32'd0);

    // Asynchronous reset mid-cycle with five queued entries
    for (int i = 0; i < 4; i++) begin
      push2(8'(8'h60 + 2 * i), 8'(8'h61 + 2 * i));
      tick();
    end
    clr_ports();
    check("ar_occ5", 32'(occupancy), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("ar_occ", 32'(occupancy), 32'd0);
    check("ar_valid", 32'(resolving_valid_branch), 32'd0);
    check("ar_drops", 32'(drop_count), 32'd0);
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    tick();

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      clr_ports();
      for (int i = 0; i < NUM_RES; i++) begin
        res_valid[i]   = ($urandom_range(0, 3) != 0);
        res_taken[i]   = 1'($urandom);
        res_mispred[i] = ($urandom_range(0, 9) == 0);
        res_packet[i]  = '{idx: 8'($urandom), bhr: 8'($urandom), ctr: 2'($urandom)};
      end
      tick();
    end
    clr_ports();
    for (int i = 0; i < 10; i++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
